// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier arbiter.
package seq_mult_pkg;

  localparam int unsigned WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_core.sv
// Shift-add multiplier datapath: one multiplier bit per cycle, LSB first, after a start pulse.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   result_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // acc_sum is the accumulator after the current bit, so the final product is available combinationally
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    addend   = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;
    acc_sum  = acc_q + addend;
    done_c   = active_q && (cnt_q == CNT_W'(WIDTH - 1));
    result_c = acc_sum;

    if (start) begin
      a_d      = a_in;
      b_d      = b_in;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = acc_sum;
      if (done_c) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : seq_mult_core

// File: rtl/seq_mult_arbiter.sv
// Two-requester arbiter in front of a shared sequential multiplier.
// Define SEQ_MULT_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module seq_mult_arbiter
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e        state_q, state_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          done_id_q, done_id_d;
  logic [PW-1:0] product_q, product_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;

  logic             pick_c;
  logic             start_c;
  logic [WIDTH-1:0] a_sel_c;
  logic [WIDTH-1:0] b_sel_c;
  logic             core_done_c;
  logic [PW-1:0]    core_result_c;

  seq_mult_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .a_in     (a_sel_c),
    .b_in     (b_sel_c),
    .done_c   (core_done_c),
    .result_c (core_result_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      product_q    <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      product_q    <= product_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Owner selection when at least one request is high
  always_comb begin
`ifdef SEQ_MULT_ARB_RR_EN
    pick_c = (req0 && req1) ? ~last_owner_q : req1;
`else
    pick_c = ~req0;
`endif
    a_sel_c = pick_c ? a1 : a0;
    b_sel_c = pick_c ? b1 : b0;
  end

  always_comb begin
    state_d      = state_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    product_d    = product_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    start_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          start_c      = 1'b1;
          owner_d      = pick_c;
          last_owner_d = pick_c;
          gnt0_d       = ~pick_c;
          gnt1_d       = pick_c;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done_c) begin
          product_d = core_result_c;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule : seq_mult_arbiter

// File: tb/tb_seq_mult_arbiter.sv
// Scoreboard bench for seq_mult_arbiter: stimulus pushes expected results, a monitor checks each done.
module tb_seq_mult_arbiter;

  localparam int unsigned W  = 6;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, busy, done, done_id;
  logic [PW-1:0] product;

  typedef struct {
    logic          id;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            gnt_cyc = 0;
  logic          rst_at_edge = 1'b0;
  logic [PW-1:0] held_exp = '0;

  seq_mult_arbiter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [PW-1:0] prod);
    exp_t e;
    e.id   = id;
    e.prod = prod;
    exp_q.push_back(e);
  endtask

  // Waits for the given requester's grant; reports cycles waited and whether the other grant appeared
  task automatic wait_gnt(input logic id, output int cycles, output bit saw_other);
    bit got;
    got = 1'b0;
    cycles = 0;
    saw_other = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      cycles++;
      if ((id ? gnt0 : gnt1) === 1'b1) saw_other = 1'b1;
      if ((id ? gnt1 : gnt0) === 1'b1) got = 1'b1;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor: exclusivity of grants, result ordering, latency and product hold
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) held_exp = '0;
    if (gnt0 || gnt1) begin
      check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      gnt_cyc = cyc;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("done_id", 32'(done_id), 32'(e.id));
        check("done_latency", 32'(cyc - gnt_cyc), 32'(W));
        held_exp = e.prod;
      end
    end else begin
      check("product_hold", 32'(product), 32'(held_exp));
    end
  end

  initial begin
    int c;
    bit o;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b0;

    // Single request
    push(1'b0, 12'd1824);
    req0 = 1'b1; a0 = 6'd57; b0 = 6'd32;
    wait_gnt(1'b0, c, o);
    check("gnt0_latency", 32'(c), 32'd1);
    check("busy_after_gnt", 32'(busy), 32'd1);
    req0 = 1'b0; a0 = 6'd63; b0 = 6'd63;
    wait_idle();

    // Zero and boundary operands
    push(1'b1, 12'd0);
    req1 = 1'b1; a1 = 6'd0; b1 = 6'd45;
    wait_gnt(1'b1, c, o);
    req1 = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    push(1'b1, 12'd63);
    req1 = 1'b1; a1 = 6'd63; b1 = 6'd1;
    wait_gnt(1'b1, c, o);
    req1 = 1'b0;
    wait_idle();

    // Simultaneous requests
    a0 = 6'd63; b0 = 6'd63; a1 = 6'd5; b1 = 6'd7;
`ifdef SEQ_MULT_ARB_RR_EN
    push(1'b0, 12'd3969);
    push(1'b1, 12'd35);
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(1'b0, c, o);
    check("rr_first_no_gnt1", 32'(o), 32'd0);
    req0 = 1'b0; a0 = 6'd0;
    wait_gnt(1'b1, c, o);
    check("rr_gap", 32'(c), 32'(W + 2));
    req1 = 1'b0;
`else
    for (int k = 0; k < 3; k++) push(1'b0, 12'd3969);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(1'b0, c, o);
      check("fixed_no_gnt1", 32'(o), 32'd0);
      if (k > 0) check("fixed_gap", 32'(c), 32'(W + 2));
    end
    req0 = 1'b0;
    push(1'b1, 12'd35);
    wait_gnt(1'b1, c, o);
    check("pending_req1_gap", 32'(c), 32'(W + 2));
    req1 = 1'b0;
`endif
    wait_idle();

    // Reset mid-operation: no done, product cleared
    req0 = 1'b1; a0 = 6'd20; b0 = 6'd20;
    wait_gnt(1'b0, c, o);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    push(1'b1, 12'd100);
    req1 = 1'b1; a1 = 6'd10; b1 = 6'd10;
    wait_gnt(1'b1, c, o);
    req1 = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seq_mult_arbiter

// File: doc/seq_mult_arbiter.md
SEQ_MULT_ARBITER -- requirements
Module: seq_mult_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 6, operand width; product width is 2*WIDTH.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0, req1  input  1 each  requester 0/1 requests a multiply.
REQ-005 SHALL have ports: a0, b0, a1, b1  input  WIDTH each  unsigned operands of requester 0/1.
REQ-006 SHALL have ports: gnt0, gnt1  output  1 each  one-cycle pulse, request accepted and operands captured.
REQ-007 SHALL have port: busy  output  1  high while a multiply is in progress or completing.
REQ-008 SHALL have ports: done  output  1  one-cycle result-valid pulse; done_id  output  1  owner of that result.
REQ-009 SHALL have port: product  output  2*WIDTH  unsigned result, held until the next done.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE; requests are sampled only in IDLE.
REQ-011 SHALL, at an edge in IDLE with any req high, pick an owner, capture its a/b, clear the accumulator and bit counter, enter RUN, and assert the owner's gnt for exactly the following cycle.
REQ-012 SHALL in RUN process one multiplier bit per edge, LSB first: if b[i]=1 then acc += a<<i, as a full 2*WIDTH-bit unsigned add with no truncation.
REQ-013 SHALL, at the edge that processes bit WIDTH-1, load product with the final accumulator, set done=1 and done_id=owner, and enter DONE.
REQ-014 SHALL return from DONE to IDLE on the next edge, so done is high exactly one cycle.
REQ-015 SHALL assert done exactly WIDTH cycles after the gnt cycle; minimum issue interval is WIDTH+2 cycles.
REQ-016 SHALL assert busy in RUN and DONE only; gnt0/gnt1 SHALL never be high together.
REQ-017 SHALL ignore req and operand changes after capture; a requester may drop req and change operands after its gnt.
REQ-018 SHALL, with both requests high in IDLE, grant per the arbitration mode in REQ-022/REQ-023.
REQ-019 SHALL treat a request that is not granted as pending while req stays high; it is not queued once req drops.

Reset
REQ-020 SHALL, with rst high at an edge, force IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, product=0, accumulator=0, counter=0, last_owner=1.
REQ-021 SHALL abort an in-progress multiply on reset mid-operation: no done pulse, product=0; rst has priority over all other events.

Configuration
REQ-022 SHALL, with macro SEQ_MULT_ARB_RR_EN defined, arbitrate round-robin: on simultaneous requests, grant the requester that is not last_owner, and update last_owner on every grant.
REQ-023 SHALL, without SEQ_MULT_ARB_RR_EN, use fixed priority (requester 0 always wins); last_owner still resets but is not used for arbitration.

Structure
REQ-024 SHALL place the FSM state encoding typedef and the default WIDTH constant in the shared package seq_mult_pkg.
REQ-025 SHALL implement the shift-add datapath (operand registers, accumulator, bit counter) as sub-module seq_mult_core with start/done handshake; arbitration and the FSM stay in the top.

Verification
REQ-026 SHALL cover the single request: req0, a0=57, b0=32 -> gnt0 one cycle after the sampling edge, done 6 cycles after gnt0, product=1824, done_id=0.
REQ-027 SHALL cover simultaneous requests with RR enabled: a0=63, b0=63 and a1=5, b1=7 held -> req0 served first (product=3969, done_id=0), then gnt1 in the cycle after return to IDLE, product=35, done_id=1.
REQ-028 SHALL cover fixed priority (macro off): req0 and req1 held high for three operations -> all three grants go to requester 0; gnt1 never asserted.
REQ-029 SHALL cover zero and boundary operands: a1=0, b1=45 -> product=0; then a1=63, b1=1 -> product=63; product holds between done pulses.
REQ-030 SHALL cover reset mid-operation: rst pulsed 3 cycles after gnt0 -> busy=0, product=0, no done; a fresh req1 (a1=10, b1=10) then completes with product=100, done_id=1.
